// File: rtl/enc8b10b_pkg.sv
// Shared constants and code tables for the multi-lane 8b/10b encoder.
// Tables hold the RD- column; the RD+ column is derived by the lane.
// Optional build macro used by the encoder files: K_CHECK_EN.
package enc8b10b_pkg;

    localparam logic [9:0] K28_5_RDN = 10'h0FA;
    localparam logic [9:0] K28_5_RDP = 10'h305;
    localparam logic [9:0] D0_0_RDN  = 10'h274;

    // Widest supported configuration is four lanes.
    localparam int LANE_IDX_W = 2;

    // Control characters that have a defined 10b code.
    localparam int N_LEGAL_K = 12;
    localparam logic [7:0] LEGAL_K [N_LEGAL_K] = '{
        8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
        8'hF7, 8'hFB, 8'hFD, 8'hFE
    };

    function automatic logic is_legal_k(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_LEGAL_K; i++) begin
            if (b == LEGAL_K[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    // 5b/6b RD- column, abcdei with a as MSB.
    function automatic logic [5:0] enc6_rdn(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:    c = 6'b100111;
            5'd1:    c = 6'b011101;
            5'd2:    c = 6'b101101;
            5'd3:    c = 6'b110001;
            5'd4:    c = 6'b110101;
            5'd5:    c = 6'b101001;
            5'd6:    c = 6'b011001;
            5'd7:    c = 6'b111000;
            5'd8:    c = 6'b111001;
            5'd9:    c = 6'b100101;
            5'd10:   c = 6'b010101;
            5'd11:   c = 6'b110100;
            5'd12:   c = 6'b001101;
            5'd13:   c = 6'b101100;
            5'd14:   c = 6'b011100;
            5'd15:   c = 6'b010111;
            5'd16:   c = 6'b011011;
            5'd17:   c = 6'b100011;
            5'd18:   c = 6'b010011;
            5'd19:   c = 6'b110010;
            5'd20:   c = 6'b001011;
            5'd21:   c = 6'b101010;
            5'd22:   c = 6'b011010;
            5'd23:   c = 6'b111010;
            5'd24:   c = 6'b110011;
            5'd25:   c = 6'b100110;
            5'd26:   c = 6'b010110;
            5'd27:   c = 6'b110110;
            5'd28:   c = 6'b001110;
            5'd29:   c = 6'b101110;
            5'd30:   c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // 3b/4b RD- column, fghj with f as MSB; alt picks A7 over P7 for x.7.
    function automatic logic [3:0] enc4_rdn(input logic [2:0] y, input logic alt);
        logic [3:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            default: c = alt ? 4'b0111 : 4'b1110;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/enc8b10b_lane.sv
// Single-byte combinational 8b/10b encoder with RD in/out for chaining.
// With K_CHECK_EN defined, an illegal K is replaced by K28.5.
module enc8b10b_lane
    import enc8b10b_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       k_i,
    input  logic       rd_in_i,
    output logic [9:0] sym_o,
    output logic       rd_out_o,
    output logic       k_illegal_o
);

    logic [4:0] x;
    logic [2:0] y;
    logic       legal_k;
    logic       k28;
    logic       rd6;
    logic       alt7;
    logic [5:0] c6;
    logic [3:0] c4;

    // Encode 6b then 4b, each sub-block choosing its column from the RD it sees.
    // NOTE: every variable gets a value on every path before use, so no latch is inferred.
    always_comb begin
        x           = data_i[4:0];
        y           = data_i[7:5];
        legal_k     = k_i && is_legal_k(data_i);
        k_illegal_o = k_i && !legal_k;
        k28         = legal_k && (x == 5'd28);

        c6 = k28 ? 6'b001111 : enc6_rdn(x);
        if (!k28 && (x == 5'd7)) begin
            c6 = rd_in_i ? 6'b000111 : 6'b111000;
        end else if (rd_in_i && ($countones(c6) != 3)) begin
            c6 = ~c6;
        end
        rd6 = ($countones(c6) > 3) ? 1'b1 :
              ($countones(c6) < 3) ? 1'b0 : rd_in_i;

        // A7 avoids a run of five equal bits across the 6b/4b boundary.
        alt7 = legal_k ||
               (rd6 ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                    : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20)));
        c4 = enc4_rdn(y, alt7);
        if (rd6 && (($countones(c4) != 2) || (y == 3'd3))) begin
            c4 = ~c4;
        end
        // Keep the comma polarity of K28.1/.5/.6 tied to the 6b block.
        if (k28 && !rd6 && ((y == 3'd1) || (y == 3'd5) || (y == 3'd6))) begin
            c4 = ~c4;
        end
        rd_out_o = ($countones(c4) > 2) ? 1'b1 :
                   ($countones(c4) < 2) ? 1'b0 : rd6;
        sym_o    = {c6, c4};

`ifdef K_CHECK_EN
        if (k_illegal_o) begin
            sym_o    = rd_in_i ? K28_5_RDP : K28_5_RDN;
            rd_out_o = !rd_in_i;
        end
`endif
    end

endmodule

// File: rtl/enc8b10b_nlane.sv
// NBYTES-wide 8b/10b encoder: lanes chained on running disparity, one
// registered output stage with valid/ready. Build macro K_CHECK_EN adds
// the k_err port and K28.5 substitution for illegal control codes.
module enc8b10b_nlane
    import enc8b10b_pkg::*;
#(
    parameter int NBYTES  = 2,
    parameter bit RD_INIT = 1'b0
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NBYTES-1:0]    in_data,
    input  logic [NBYTES-1:0]      in_k,
    input  logic                   rd_load,
    input  logic                   rd_load_val,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [10*NBYTES-1:0]   out_sym,
    output logic                   out_rd
`ifdef K_CHECK_EN
    ,
    output logic [NBYTES-1:0]      k_err
`endif
);

    logic                  out_valid_q;
    logic [10*NBYTES-1:0]  sym_q;
    logic [10*NBYTES-1:0]  sym_d;
    logic                  out_rd_q;
    logic                  rd_q;
    logic                  rd_d;
    logic                  lane0_rd;
    logic                  accept;
    logic [NBYTES-1:0]     k_illegal_d;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    // A load strobe coinciding with an accept seeds lane 0 directly.
    assign lane0_rd  = rd_load ? rd_load_val : rd_q;
    assign out_valid = out_valid_q;
    assign out_sym   = sym_q;
    assign out_rd    = out_rd_q;

    for (genvar i = 0; i < NBYTES; i++) begin : g_lane
        logic       rd_in;
        logic       rd_out;
        logic [9:0] sym;
        logic       k_ill;

        if (i == 0) begin : g_head
            assign rd_in = lane0_rd;
        end else begin : g_tail
            assign rd_in = g_lane[i-1].rd_out;
        end

        enc8b10b_lane u_lane (
            .data_i      (in_data[8*i +: 8]),
            .k_i         (in_k[i]),
            .rd_in_i     (rd_in),
            .sym_o       (sym),
            .rd_out_o    (rd_out),
            .k_illegal_o (k_ill)
        );

        assign sym_d[10*i +: 10] = sym;
        assign k_illegal_d[i]    = k_ill;
    end

    assign rd_d = g_lane[NBYTES-1].rd_out;

`ifdef K_CHECK_EN
    logic [NBYTES-1:0] k_err_q;
    assign k_err = k_err_q;
`else
    logic unused_k_illegal;
    assign unused_k_illegal = ^k_illegal_d;
`endif

    // Output register and disparity state; RD moves only on accept or load.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            sym_q       <= '0;
            out_rd_q    <= RD_INIT;
            rd_q        <= RD_INIT;
`ifdef K_CHECK_EN
            k_err_q     <= '0;
`endif
        end else if (accept) begin
            out_valid_q <= 1'b1;
            sym_q       <= sym_d;
            out_rd_q    <= rd_d;
            rd_q        <= rd_d;
`ifdef K_CHECK_EN
            k_err_q     <= k_illegal_d;
`endif
        end else begin
            if (out_ready) out_valid_q <= 1'b0;
            if (rd_load)   rd_q        <= rd_load_val;
        end
    end

endmodule

// File: tb/tb_enc8b10b_nlane.sv
// Self-checking bench for enc8b10b_nlane (NBYTES=2, RD_INIT=0): directed
// cases followed by randomized traffic against a table-driven reference.
module tb_enc8b10b_nlane;

    localparam int NB = 2;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [8*NB-1:0] in_data;
    logic [NB-1:0]   in_k;
    logic            rd_load;
    logic            rd_load_val;
    logic            out_valid;
    logic            out_ready;
    logic [10*NB-1:0] out_sym;
    logic            out_rd;
`ifdef K_CHECK_EN
    logic [NB-1:0]   k_err;
`endif

    enc8b10b_nlane #(.NBYTES(NB), .RD_INIT(1'b0)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_k        (in_k),
        .rd_load     (rd_load),
        .rd_load_val (rd_load_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sym     (out_sym),
        .out_rd      (out_rd)
`ifdef K_CHECK_EN
        ,
        .k_err       (k_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // RD- columns of the standard tables; RD+ entries are derived below.
    localparam logic [5:0] T6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
    };
    localparam logic [3:0] T4 [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
    };
    localparam logic [7:0] KLIST [12] = '{
        8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE
    };

    function automatic logic ref_legal(input logic [7:0] b);
        int x, y;
        x = int'(b[4:0]);
        y = int'(b[7:5]);
        return (x == 28) || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30));
    endfunction

    // Disparity after a block: compare its ones count with half its width.
    function automatic logic rd_after(input int ones, input int width, input logic rd);
        if (2 * ones > width) return 1'b1;
        if (2 * ones < width) return 1'b0;
        return rd;
    endfunction

    // Returns {rd_out, symbol[9:0]}.
    function automatic logic [10:0] ref_enc(input logic [7:0] b, input logic k, input logic rd);
        int x, y;
        logic legal, r, a7;
        logic [5:0] s6;
        logic [3:0] s4;
        x = int'(b[4:0]);
        y = int'(b[7:5]);
        legal = k && ref_legal(b);
`ifdef K_CHECK_EN
        if (k && !legal) return rd ? {1'b0, 10'h305} : {1'b1, 10'h0FA};
`endif
        if (legal && x == 28)      s6 = rd ? 6'b110000 : 6'b001111;
        else if (x == 7)           s6 = rd ? 6'b000111 : 6'b111000;
        else if ($countones(T6[x]) == 3) s6 = T6[x];
        else                       s6 = rd ? ~T6[x] : T6[x];
        r = (x == 7 && !(legal && x == 28)) ? rd : rd_after($countones(s6), 6, rd);

        if (y == 7) begin
            a7 = legal || (!r && (x == 17 || x == 18 || x == 20)) || (r && (x == 11 || x == 13 || x == 14));
            if (a7) s4 = r ? 4'b1000 : 4'b0111;
            else    s4 = r ? 4'b0001 : 4'b1110;
        end else if (legal && x == 28 && (y == 1 || y == 5 || y == 6)) begin
            s4 = r ? T4[y] : ~T4[y];
        end else if (y == 3) begin
            s4 = r ? 4'b0011 : 4'b1100;
        end else if ($countones(T4[y]) == 2) begin
            s4 = T4[y];
        end else begin
            s4 = r ? ~T4[y] : T4[y];
        end
        r = (y == 3) ? r : rd_after($countones(s4), 4, r);
        return {r, s6, s4};
    endfunction

    // Model state: what the output register and RD must hold.
    logic            exp_valid;
    logic [10*NB-1:0] exp_sym;
    logic            exp_rd;
    logic            model_rd;
    logic [NB-1:0]   exp_kerr;
    logic            model_known = 1'b0;

    task automatic step(input logic v, input logic [8*NB-1:0] d, input logic [NB-1:0] k,
                        input logic ordy, input logic ld, input logic ldv, input logic rst);
        logic exp_ready;
        logic r;
        logic [10:0] res;
        in_valid    = v;
        in_data     = d;
        in_k        = k;
        out_ready   = ordy;
        rd_load     = ld;
        rd_load_val = ldv;
        reset       = rst;
        #1;
        exp_ready = !exp_valid || ordy;
        if (model_known) check("in_ready", in_ready, exp_ready);

        if (rst) begin
            exp_valid = 1'b0;
            exp_sym   = '0;
            exp_rd    = 1'b0;
            model_rd  = 1'b0;
            exp_kerr  = '0;
        end else if (v && exp_ready) begin
            r = ld ? ldv : model_rd;
            for (int i = 0; i < NB; i++) begin
                res = ref_enc(d[8*i +: 8], k[i], r);
                exp_sym[10*i +: 10] = res[9:0];
                exp_kerr[i] = k[i] && !ref_legal(d[8*i +: 8]);
                r = res[10];
            end
            exp_rd    = r;
            model_rd  = r;
            exp_valid = 1'b1;
        end else begin
            if (ordy) exp_valid = 1'b0;
            if (ld)   model_rd  = ldv;
        end

        @(posedge clk);
        #1;
        if (rst) model_known = 1'b1;
        if (model_known) begin
            check("out_valid", out_valid, exp_valid);
            check("out_sym", out_sym, exp_sym);
            check("out_rd", out_rd, exp_rd);
`ifdef K_CHECK_EN
            check("k_err", k_err, exp_kerr);
`endif
        end
    endtask

    function automatic logic [8:0] rand_lane();
        logic [7:0] b;
        logic k;
        k = ($urandom_range(3) == 0);
        if (k && $urandom_range(3) != 0) b = KLIST[$urandom_range(11)];
        else b = 8'($urandom_range(255));
        return {k, b};
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] l0, l1;
        in_valid = 0; in_data = '0; in_k = '0; rd_load = 0; rd_load_val = 0;
        out_ready = 1; reset = 1;
        exp_valid = 0; exp_sym = '0; exp_rd = 0; model_rd = 0; exp_kerr = '0;

        // Pin the reference to hand-encoded symbols.
        check("model K28.5 RD-", ref_enc(8'hBC, 1'b1, 1'b0), 11'h4FA);
        check("model K28.5 RD+", ref_enc(8'hBC, 1'b1, 1'b1), 11'h305);
        check("model D0.0 RD-", ref_enc(8'h00, 1'b0, 1'b0), 11'h274);
        check("model D21.5 RD-", ref_enc(8'hB5, 1'b0, 1'b0), 11'h2AA);
        check("model D17.7 RD-", ref_enc(8'hF1, 1'b0, 1'b0), 11'h637);
        check("model D11.7 RD+", ref_enc(8'hEB, 1'b0, 1'b1), 11'h348);
        check("model K28.7 RD-", ref_enc(8'hFC, 1'b1, 1'b0), 11'h0F8);

        step(0, 16'h0, 2'b00, 1, 0, 0, 1);
        step(0, 16'h0, 2'b00, 1, 0, 0, 1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_sym", out_sym, 20'h0);
        check("reset out_rd", out_rd, 1'b0);
        step(0, 16'h0, 2'b00, 1, 0, 0, 0);
        check("in_ready after reset", in_ready, 1'b1);

        // K28.5 pair starting at RD-.
        step(1, 16'hBCBC, 2'b11, 1, 0, 0, 0);
        check("K28.5 pair sym", out_sym, 20'hC14FA);
        check("K28.5 pair rd", out_rd, 1'b0);

        // D0.0 then D21.5: both balanced overall, RD stays negative.
        step(1, 16'hB500, 2'b00, 1, 0, 0, 0);
        check("D0.0/D21.5 sym", out_sym, 20'hAAA74);
        check("D0.0/D21.5 rd", out_rd, 1'b0);

        // Backpressure: output must hold, nothing accepted.
        for (int i = 0; i < 3; i++) begin
            step(1, 16'($urandom_range(65535)), 2'b00, 0, 0, 0, 0);
            check("stall in_ready", in_ready, 1'b0);
            check("stall sym held", out_sym, 20'hAAA74);
        end
        step(0, 16'h0, 2'b00, 1, 0, 0, 0);
        check("single transfer", out_valid, 1'b0);
        step(0, 16'h0, 2'b00, 1, 0, 0, 0);

        // A7 selection on both polarities within one word.
        step(1, 16'hEBF1, 2'b00, 1, 0, 0, 0);
        check("D17.7/D11.7 sym", out_sym, 20'hD2237);
        check("D17.7/D11.7 rd", out_rd, 1'b0);

        // RD preset without accept, then K28.5 pair from RD+.
        step(0, 16'h0, 2'b00, 1, 1, 1, 0);
        step(1, 16'hBCBC, 2'b11, 1, 0, 0, 0);
        check("preset K28.5 sym", out_sym, 20'h3EB05);
        check("preset K28.5 rd", out_rd, 1'b1);

        // Reset while a word is held.
        step(1, 16'h1234, 2'b00, 0, 0, 0, 1);
        check("midreset out_valid", out_valid, 1'b0);
        check("midreset out_rd", out_rd, 1'b0);

`ifdef K_CHECK_EN
        // Illegal K on lane 0 becomes K28.5; lane 1 D0.0 then sees RD+.
        step(1, 16'h0000, 2'b01, 1, 0, 0, 0);
        check("illegal K k_err", k_err, 2'b01);
        check("illegal K sym", out_sym, 20'h62CFA);
`endif

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            l0 = rand_lane();
            l1 = rand_lane();
            step($urandom_range(3) != 0, {l1[7:0], l0[7:0]}, {l1[8], l0[8]},
                 $urandom_range(3) != 0, $urandom_range(15) == 0, 1'($urandom_range(1)),
                 $urandom_range(399) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
